// File: rtl/piso_tx_sched.sv
// Round-robin scheduler feeding NREQ word producers into one MSB-first serial shift path.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_tx_sched #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int GAP   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*WIDTH-1:0]         req_data,
   output logic [NREQ-1:0]               req_ready,
   output logic                          dout,
   output logic                          frame,
   output logic                          busy,
   output logic [$clog2(NREQ)-1:0]       grant_id
);

   localparam int IW = $clog2(NREQ);
`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CW = $clog2(FLEN + GAP + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [WIDTH-2:0]  shreg;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     win;
   logic              win_vld;
   logic [WIDTH-1:0]  word;
`ifdef PISO_PARITY_EN
   logic              par;
`endif

   // Search starts one past the last grant and wraps, so the last winner ranks lowest.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!win_vld && req_valid[(32'(ptr) + k) % NREQ]) begin
            win     = IW'((32'(ptr) + k) % NREQ);
            win_vld = 1'b1;
         end
      end
      word = req_data[win*WIDTH +: WIDTH];
   end

   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && win_vld && !rst)
         req_ready[win] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (win_vld) state_nx = ST_SHIFT;
         ST_SHIFT: if (cnt == CW'(FLEN - 1)) state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:   if (cnt == CW'(GAP - 1)) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         shreg    <= '0;
         ptr      <= IW'(NREQ - 1);
         grant_id <= '0;
         dout     <= 1'b0;
         frame    <= 1'b0;
`ifdef PISO_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  shreg    <= word[WIDTH-2:0];
                  dout     <= word[WIDTH-1];
                  frame    <= 1'b1;
                  grant_id <= win;
                  ptr      <= win;
                  cnt      <= '0;
`ifdef PISO_PARITY_EN
                  par      <= ^word;
`endif
               end
            end
            ST_SHIFT: begin
               if (cnt == CW'(FLEN - 1)) begin
                  frame <= 1'b0;
                  dout  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 1'b1;
                  shreg <= shreg << 1;
`ifdef PISO_PARITY_EN
                  if (cnt == CW'(WIDTH - 1))
                     dout <= par;
                  else
                     dout <= shreg[WIDTH-2];
`else
                  dout <= shreg[WIDTH-2];
`endif
               end
            end
            ST_GAP: begin
               if (cnt == CW'(GAP - 1))
                  cnt <= '0;
               else
                  cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Random and directed bench for piso_tx_sched: one GAP=1 and one GAP=0 instance
// checked every cycle against a frame-position reference model.
module tb_piso_tx_sched;

   localparam int W = 16;
   localparam int N = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    valid;
   logic [N*W-1:0]  data;
   logic [N-1:0]    rdy [2];
   logic            dv  [2];
   logic            fv  [2];
   logic            bv  [2];
   logic [1:0]      gv  [2];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   bit mon_on = 1'b0;

   int          mpos  [2];
   int          mptr  [2];
   int          mgid  [2];
   logic [W-1:0] mword [2];
   int          glen  [2];

   int gq[$];
   int gt[$];
   int g1t[$];

   always #5 clk = ~clk;

   piso_tx_sched #(.WIDTH(W), .NREQ(N), .GAP(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(valid), .req_data(data),
      .req_ready(rdy[0]), .dout(dv[0]), .frame(fv[0]), .busy(bv[0]), .grant_id(gv[0])
   );

   piso_tx_sched #(.WIDTH(W), .NREQ(N), .GAP(0)) dut1 (
      .clk(clk), .rst(rst), .req_valid(valid), .req_data(data),
      .req_ready(rdy[1]), .dout(dv[1]), .frame(fv[1]), .busy(bv[1]), .grant_id(gv[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: mpos is the position inside the current frame+gap (-1 when idle).
   int   len, w, idx;
   logic ed, ef, eb;
   logic [N-1:0] er;
   always @(negedge clk) begin
      if (mon_on) begin
         for (int j = 0; j < 2; j++) begin
            len = FL + glen[j];
            if (mpos[j] < 0) begin
               ef = 1'b0; ed = 1'b0; eb = 1'b0;
            end else if (mpos[j] < W) begin
               ef = 1'b1; ed = mword[j][W-1-mpos[j]]; eb = 1'b1;
            end else if (mpos[j] < FL) begin
               ef = 1'b1; ed = ^mword[j]; eb = 1'b1;
            end else begin
               ef = 1'b0; ed = 1'b0; eb = 1'b1;
            end
            check($sformatf("dout%0d", j),  dv[j], ed);
            check($sformatf("frame%0d", j), fv[j], ef);
            check($sformatf("busy%0d", j),  bv[j], eb);
            check($sformatf("gid%0d", j),   gv[j], mgid[j]);
            if (rst) begin
               check($sformatf("ready_rst%0d", j), rdy[j], 0);
               mpos[j] = -1; mptr[j] = N - 1; mgid[j] = 0;
            end else if (mpos[j] < 0) begin
               w = -1;
               for (int k = 1; k <= N; k++) begin
                  idx = (mptr[j] + k) % N;
                  if (w < 0 && valid[idx]) w = idx;
               end
               er = (w >= 0) ? N'(1) << w : '0;
               check($sformatf("ready%0d", j), rdy[j], er);
               if (w >= 0) begin
                  mword[j] = data[w*W +: W];
                  mpos[j] = 0; mptr[j] = w; mgid[j] = w;
                  if (j == 0) begin gq.push_back(w); gt.push_back(cyc); end
                  else g1t.push_back(cyc);
               end
            end else begin
               check($sformatf("ready_busy%0d", j), rdy[j], 0);
               mpos[j]++;
               if (mpos[j] == len) mpos[j] = -1;
            end
         end
      end
      cyc++;
   end

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      glen[0] = 1; glen[1] = 0;
      for (int j = 0; j < 2; j++) begin
         mpos[j] = -1; mptr[j] = N - 1; mgid[j] = 0; mword[j] = '0;
      end
      rst = 1'b1; valid = '0; data = '0;
      tick();
      mon_on = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // single request
      data[0 +: W] = 16'hA5C3;
      valid = 4'b0001;
      tick();
      valid = '0;
      repeat (25) tick();
      check("p1_ngrant", gq.size(), 1);
      if (gq.size() > 0) check("p1_gid", gq[0], 0);

      // all requesters valid
      pulse_rst();
      gq.delete(); gt.delete();
      data = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
      valid = 4'b1111;
      repeat (5 * (FL + 2) + 3) tick();
      check("p2_ngrant", gq.size() >= 5, 1);
      if (gq.size() >= 5) begin
         for (int i = 0; i < 5; i++) check($sformatf("p2_order%0d", i), gq[i], i % N);
         for (int i = 1; i < 5; i++) check($sformatf("p2_spacing%0d", i), gt[i] - gt[i-1], FL + 2);
      end

      // fairness after partial traffic
      valid = '0;
      pulse_rst();
      repeat (2) tick();
      gq.delete();
      valid = 4'b0100;
      tick();
      valid = 4'b0101;
      repeat (2 * (FL + 2) + 2) tick();
      check("p3_ngrant", gq.size() >= 3, 1);
      if (gq.size() >= 3) begin
         check("p3_first", gq[0], 2);
         check("p3_wrap", gq[1], 0);
         check("p3_next", gq[2], 2);
      end

      // reset mid-frame at bit 7
      valid = '0;
      pulse_rst();
      valid = 4'b1111;
      tick();
      repeat (7) tick();
      pulse_rst();
      check("p4_dout", dv[0], 0);
      check("p4_frame", fv[0], 0);
      check("p4_busy", bv[0], 0);
      gq.delete();
      repeat (3) tick();
      check("p4_ngrant", gq.size(), 1);
      if (gq.size() > 0) check("p4_gid", gq[0], 0);

      // GAP=0 instance with requester 1 held
      valid = '0;
      pulse_rst();
      g1t.delete();
      data = {$urandom, $urandom};
      valid = 4'b0010;
      repeat (4 * (FL + 1) + 2) tick();
      check("p5_ngrant", g1t.size() >= 4, 1);
      if (g1t.size() >= 4)
         for (int i = 1; i < 4; i++) check($sformatf("p5_spacing%0d", i), g1t[i] - g1t[i-1], FL + 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         valid = N'($urandom);
         data  = {$urandom, $urandom};
         rst   = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      valid = '0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
